traffic_phase_ctrl: RTL and testbench

Parametrised N-phase traffic signal controller. It generalises the fixed 8-state NS/EW sequencer into a round-robin phase engine. New features over that sequencer:
- Latched demand with skipping of idle phases
- Programmable all-red clearance
- Emergency preemption to any phase
- Flashing-red fail-safe mode

It sits between the debounced detector/request inputs and the lamp drivers.

---
 rtl/traffic_phase_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase round-robin traffic signal controller.
// Serves one phase at a time through GREEN -> YELLOW -> ALLRED, skipping
// phases without latched demand, with emergency preemption and a
// flashing-red fail-safe. All state changes happen on the 1 s tick.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// M_GREEN  | cur_phase shows green, every other group red
// M_YELLOW | cur_phase shows yellow, every other group red
// M_ALLRED | clearance interval, every group red
// M_FLASH  | fail-safe, every group flashes red in step with the tick
module traffic_phase_ctrl #(
   parameter int NUM_PHASES = 4,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int G_MIN      = 60,
   parameter int G_MAX      = 90,
   parameter int Y_SEC      = 10,
   parameter int AR_SEC     = 2,
   localparam int PW        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_PHASES-1:0]     req,
   input  logic                      preempt,
   input  logic [PW-1:0]             preempt_phase,
   input  logic                      flash,
   output logic [3*NUM_PHASES-1:0]   lights,
   output logic [PW-1:0]             cur_phase,
   output logic [1:0]                mode,
   output logic [NUM_PHASES-1:0]     req_pending,
   output logic                      tick
);

   localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

   localparam logic [CW-1:0] CLK_LAST   = CW'(CLK_FREQ - 1);
   localparam logic [7:0]    G_MIN_LAST = 8'(G_MIN - 1);
   localparam logic [7:0]    G_MAX_LAST = 8'(G_MAX - 1);
   localparam logic [7:0]    Y_LAST     = 8'(Y_SEC - 1);
   localparam logic [7:0]    AR_LAST    = 8'(AR_SEC - 1);
   localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);
   localparam logic [PW:0]   NP_W       = (PW+1)'(NUM_PHASES);

   typedef enum logic [1:0] {
      M_GREEN  = 2'd0,
      M_YELLOW = 2'd1,
      M_ALLRED = 2'd2,
      M_FLASH  = 2'd3
   } mode_t;

   mode_t                 mode_q;
   mode_t                 mode_nx;
   logic [PW-1:0]         phase_q;
   logic [PW-1:0]         phase_nx;
   logic [7:0]            sec_cnt;
   logic [CW-1:0]         clk_cnt;
   logic [NUM_PHASES-1:0] pending_q;
   logic [NUM_PHASES-1:0] pending_d;
   logic [NUM_PHASES-1:0] cur_mask;
   logic [NUM_PHASES-1:0] next_mask;
   logic                  flash_r;
   logic                  preempt_ok;
   logic                  other_req;
   logic                  enter_green;
   logic [PW-1:0]         inc_phase;
   logic [PW-1:0]         rr_phase;
   logic [PW-1:0]         pick_phase;
   logic [PW-1:0]         rr_idx;
   logic [PW:0]           rr_sum;
   logic                  rr_found;

   assign tick        = (clk_cnt == CLK_LAST);
   assign cur_phase   = phase_q;
   assign mode        = mode_q;
   assign req_pending = pending_q;

   // Out-of-range preempt targets are treated as no preemption at all.
   assign preempt_ok  = preempt && (int'(preempt_phase) < NUM_PHASES);
   assign other_req   = |(pending_q & ~cur_mask);
   assign inc_phase   = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
   assign pick_phase  = preempt_ok ? preempt_phase : rr_phase;
   assign enter_green = tick && (mode_nx == M_GREEN) && (mode_q != M_GREEN);

   // Free-running second prescaler; wraps on the tick cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_cnt <= '0;
      end else if (tick) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end

   // One-hot masks for the served phase and the phase about to be entered.
   always_comb begin
      cur_mask            = '0;
      next_mask           = '0;
      cur_mask[phase_q]   = 1'b1;
      next_mask[phase_nx] = 1'b1;
   end

   // Round-robin search for the next phase with latched demand, starting
   // after cur_phase; the current phase itself is considered last.
   always_comb begin
      rr_found = 1'b0;
      rr_phase = inc_phase;
      rr_sum   = '0;
      rr_idx   = '0;
      for (int i = 1; i <= NUM_PHASES; i++) begin
         rr_sum = {1'b0, phase_q} + (PW+1)'(i);
         if (rr_sum >= NP_W) begin
            rr_sum = rr_sum - NP_W;
         end
         rr_idx = rr_sum[PW-1:0];
         if (!rr_found && pending_q[rr_idx]) begin
            rr_found = 1'b1;
            rr_phase = rr_idx;
         end
      end
   end

   // Next mode/phase, only committed on a tick; flash outranks everything.
   always_comb begin
      mode_nx  = mode_q;
      phase_nx = phase_q;
      if (flash && (mode_q != M_FLASH)) begin
         mode_nx = M_FLASH;
      end else begin
         case (mode_q)
            M_FLASH: begin
               if (!flash) begin
                  // Park on the last phase so default rotation resumes at 0.
                  mode_nx  = M_ALLRED;
                  phase_nx = LAST_PHASE;
               end
            end
            M_GREEN: begin
               if (preempt_ok) begin
                  if (preempt_phase != phase_q) begin
                     mode_nx = M_YELLOW;
                  end
               end else if ((sec_cnt >= G_MIN_LAST) &&
                            (other_req || (sec_cnt >= G_MAX_LAST))) begin
                  mode_nx = M_YELLOW;
               end
            end
            M_YELLOW: begin
               if (sec_cnt == Y_LAST) begin
                  mode_nx = M_ALLRED;
               end
            end
            M_ALLRED: begin
               if (sec_cnt == AR_LAST) begin
                  mode_nx  = M_GREEN;
                  phase_nx = pick_phase;
               end
            end
            default: begin
               mode_nx = M_FLASH;
            end
         endcase
      end
   end

   // State register: mode and served phase advance only on ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= M_GREEN;
         phase_q <= '0;
      end else if (tick) begin
         mode_q  <= mode_nx;
         phase_q <= phase_nx;
      end
   end

   // Dwell counter and flash phase, both stepped by the tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_cnt <= '0;
         flash_r <= 1'b1;
      end else if (tick) begin
         if ((mode_nx != mode_q) || (phase_nx != phase_q)) begin
            sec_cnt <= '0;
         end else if (sec_cnt != 8'hFF) begin
            sec_cnt <= sec_cnt + 1'b1;
         end
         if ((mode_nx == M_FLASH) && (mode_q != M_FLASH)) begin
            flash_r <= 1'b1;
         end else if (mode_q == M_FLASH) begin
            flash_r <= ~flash_r;
         end
      end
   end

   // Demand latch: a request for the phase already in green is dropped,
   // and clearing on green entry beats a same-cycle set.
   always_comb begin
      pending_d = pending_q | (req & ((mode_q == M_GREEN) ? ~cur_mask : '1));
      if (enter_green) begin
         pending_d = pending_d & ~next_mask;
      end
   end

   // Demand register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Lamp decode, {R,Y,G} per group, purely from the registered state.
   always_comb begin
      lights = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         case (mode_q)
            M_GREEN:  lights[3*k +: 3] = (k == int'(phase_q)) ? 3'b001 : 3'b100;
            M_YELLOW: lights[3*k +: 3] = (k == int'(phase_q)) ? 3'b010 : 3'b100;
            M_ALLRED: lights[3*k +: 3] = 3'b100;
            default:  lights[3*k +: 3] = {flash_r, 2'b00};
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a tick-level behavioural model checked
// against the DUT every cycle, plus directed scenarios with literal checks.
module tb_traffic_phase_ctrl;

   localparam int NP   = 4;
   localparam int CF   = 4;
   localparam int GMIN = 3;
   localparam int GMAX = 6;
   localparam int YS   = 2;
   localparam int ARS  = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic        preempt = 1'b0;
   logic [1:0]  preempt_phase = '0;
   logic        flash = 1'b0;
   logic [11:0] lights;
   logic [1:0]  cur_phase;
   logic [1:0]  mode;
   logic [3:0]  req_pending;
   logic        tick;

   int checks = 0;
   int failures = 0;

   traffic_phase_ctrl #(
      .NUM_PHASES(NP), .CLK_FREQ(CF), .G_MIN(GMIN), .G_MAX(GMAX),
      .Y_SEC(YS), .AR_SEC(ARS)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .preempt(preempt),
      .preempt_phase(preempt_phase), .flash(flash), .lights(lights),
      .cur_phase(cur_phase), .mode(mode), .req_pending(req_pending),
      .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: interval kind (0 green,1 yellow,2 all-red,3 flash), served phase,
   // whole ticks already spent in the interval, cycles since reset.
   int         m_mode;
   int         m_phase;
   int         m_spent;
   int         m_cyc;
   logic [3:0] m_pend;
   logic       m_flash;
   bit         m_valid = 1'b0;

   function automatic int next_served(input int from, input logic [3:0] pend);
      for (int i = 1; i <= NP; i++) begin
         if (pend[(from + i) % NP]) return (from + i) % NP;
      end
      return (from + 1) % NP;
   endfunction

   function automatic logic [11:0] lamp_word(input int md, input int ph, input logic fl);
      logic [11:0] v;
      v = '0;
      for (int k = 0; k < NP; k++) begin
         if (md == 3)                    v[3*k +: 3] = {fl, 2'b00};
         else if (md == 2 || k != ph)    v[3*k +: 3] = 3'b100;
         else if (md == 0)               v[3*k +: 3] = 3'b001;
         else                            v[3*k +: 3] = 3'b010;
      end
      return v;
   endfunction

   always @(posedge clk) begin : model
      bit         at_tick;
      bit         pv;
      bit         others;
      int         nm;
      int         nph;
      logic [3:0] pend_new;
      if (rst) begin
         m_mode = 0; m_phase = 0; m_spent = 0; m_cyc = 0;
         m_pend = '0; m_flash = 1'b1; m_valid = 1'b1;
      end else if (m_valid) begin
         at_tick  = ((m_cyc % CF) == CF - 1);
         pv       = preempt && (int'(preempt_phase) < NP);
         others   = 1'b0;
         for (int k = 0; k < NP; k++) if (k != m_phase && m_pend[k]) others = 1'b1;
         pend_new = m_pend;
         for (int k = 0; k < NP; k++) begin
            if (req[k] && !(m_mode == 0 && k == m_phase)) pend_new[k] = 1'b1;
         end
         if (at_tick) begin
            nm  = m_mode;
            nph = m_phase;
            if (flash && m_mode != 3) nm = 3;
            else if (m_mode == 3) begin
               if (!flash) begin nm = 2; nph = NP - 1; end
            end else if (m_mode == 0) begin
               if (pv) begin
                  if (int'(preempt_phase) != m_phase) nm = 1;
               end else if (m_spent + 1 >= GMIN && (others || m_spent + 1 >= GMAX)) nm = 1;
            end else if (m_mode == 1) begin
               if (m_spent + 1 == YS) nm = 2;
            end else if (m_spent + 1 == ARS) begin
               nm  = 0;
               nph = pv ? int'(preempt_phase) : next_served(m_phase, m_pend);
            end
            if (nm == 0 && m_mode != 0) pend_new[nph] = 1'b0;
            if (nm == 3 && m_mode != 3) m_flash = 1'b1;
            else if (m_mode == 3) m_flash = ~m_flash;
            if (nm != m_mode || nph != m_phase) m_spent = 0;
            else if (m_spent < 255) m_spent = m_spent + 1;
            m_mode  = nm;
            m_phase = nph;
         end
         m_pend = pend_new;
         m_cyc  = m_cyc + 1;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("lights", 32'(lights), 32'(lamp_word(m_mode, m_phase, m_flash)));
         chk("cur_phase", 32'(cur_phase), m_phase);
         chk("mode", 32'(mode), m_mode);
         chk("req_pending", 32'(req_pending), 32'(m_pend));
         chk("tick", 32'(tick), ((m_cyc % CF) == CF - 1) ? 1 : 0);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; preempt = 1'b0; preempt_phase = '0; flash = 1'b0;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: idle rotation on G_MAX
      do_reset();
      step(24);
      chk("s1_yellow_mode", 32'(mode), 1);
      chk("s1_yellow_phase", 32'(cur_phase), 0);
      step(12);
      chk("s1_phase1", 32'(cur_phase), 1);
      chk("s1_phase1_lights", 32'(lights), 32'(12'b100100001100));
      step(108);
      chk("s1_wrap_phase", 32'(cur_phase), 0);
      chk("s1_wrap_mode", 32'(mode), 0);

      // 2: single request skips phase 1
      do_reset();
      req = 4'b0100; step(1); req = '0;
      chk("s2_latched", 32'(req_pending), 32'(4'b0100));
      step(11);
      chk("s2_yellow", 32'(mode), 1);
      step(8);
      chk("s2_allred", 32'(mode), 2);
      chk("s2_still_pending", 32'(req_pending), 32'(4'b0100));
      step(4);
      chk("s2_served", 32'(cur_phase), 2);
      chk("s2_green", 32'(mode), 0);
      chk("s2_cleared", 32'(req_pending), 0);

      // 3: two requests served in order, own-phase request dropped
      do_reset();
      req = 4'b1011; step(1); req = '0;
      chk("s3_latched", 32'(req_pending), 32'(4'b1010));
      step(23);
      chk("s3_phase1", 32'(cur_phase), 1);
      chk("s3_pend_after1", 32'(req_pending), 32'(4'b1000));
      step(24);
      chk("s3_phase3", 32'(cur_phase), 3);
      chk("s3_green3", 32'(mode), 0);
      chk("s3_pend_empty", 32'(req_pending), 0);

      // 4: preemption to phase 3, held, then normal exit
      do_reset();
      preempt = 1'b1; preempt_phase = 2'd3;
      step(4);
      chk("s4_yellow", 32'(mode), 1);
      step(12);
      chk("s4_phase3", 32'(cur_phase), 3);
      chk("s4_green", 32'(mode), 0);
      step(80);
      chk("s4_held", 32'(mode), 0);
      preempt = 1'b0;
      step(4);
      chk("s4_release_yellow", 32'(mode), 1);
      step(12);
      chk("s4_next_phase0", 32'(cur_phase), 0);

      // 5: flash from mid-yellow and recovery
      do_reset();
      step(25);
      flash = 1'b1;
      step(3);
      chk("s5_flash_mode", 32'(mode), 3);
      chk("s5_flash_on", 32'(lights), 32'(12'b100100100100));
      step(4);
      chk("s5_flash_off", 32'(lights), 0);
      step(4);
      chk("s5_flash_on2", 32'(lights), 32'(12'b100100100100));
      flash = 1'b0;
      step(4);
      chk("s5_allred", 32'(mode), 2);
      chk("s5_parked", 32'(cur_phase), 3);
      step(4);
      chk("s5_phase0", 32'(cur_phase), 0);
      chk("s5_lights", 32'(lights), 32'(12'b100100100001));

      // 6: reset during all-red with demand latched
      do_reset();
      step(25);
      req = 4'b1010; step(1); req = '0;
      step(6);
      chk("s6_allred", 32'(mode), 2);
      chk("s6_pending", 32'(req_pending), 32'(4'b1010));
      rst = 1'b1; step(1); rst = 1'b0;
      chk("s6_rst_mode", 32'(mode), 0);
      chk("s6_rst_phase", 32'(cur_phase), 0);
      chk("s6_rst_pending", 32'(req_pending), 0);
      chk("s6_rst_lights", 32'(lights), 32'(12'b100100100001));
      chk("s6_rst_tick", 32'(tick), 0);
      step(2);
      chk("s6_no_tick_yet", 32'(tick), 0);
      step(1);
      chk("s6_first_tick", 32'(tick), 1);

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
